// File: rtl/updn_pkg.sv
// Shared encodings for the parameterised up/down counter: count modes and
// the ping-pong direction FSM states.
package updn_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  // The FSM state doubles as the DIR output: 1 = counting up.
  typedef enum logic {
    ST_DOWN = 1'b0,
    ST_UP   = 1'b1
  } dir_state_e;

endpackage

// File: rtl/updn_dir_fsm.sv
// Direction FSM plus bound compare: given the current count and mode, produces
// the next count value and owns the direction register (reported as o_dir).
module updn_dir_fsm
  import updn_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_step,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_count,
  output logic [WIDTH-1:0] o_next_count,
  output logic             o_dir,
  output dir_state_e       o_state
);

  localparam logic [WIDTH-1:0] L_MIN = MIN_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] L_MAX = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] L_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  dir_state_e r_state;
  dir_state_e w_state_nxt;
  logic       w_at_max;
  logic       w_at_min;

  assign w_at_max = (i_count == L_MAX);
  assign w_at_min = (i_count == L_MIN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_UP;
    else          r_state <= w_state_nxt;
  end

  // Bound checks come before the +/-1 so the WIDTH-bit arithmetic never
  // leaves [MIN_VAL, MAX_VAL], even when MAX_VAL is the all-ones value.
  always_comb begin
    w_state_nxt  = r_state;
    o_next_count = i_count;
    if (i_step) begin
      unique case (mode_e'(i_mode))
        MODE_UP: begin
          w_state_nxt  = ST_UP;
          o_next_count = w_at_max ? L_MIN : i_count + L_ONE;
        end
        MODE_DOWN: begin
          w_state_nxt  = ST_DOWN;
          o_next_count = w_at_min ? L_MAX : i_count - L_ONE;
        end
        MODE_PINGPONG: begin
          if (r_state == ST_UP) begin
            if (w_at_max) begin
              w_state_nxt  = ST_DOWN;
              o_next_count = L_MAX - L_ONE;
            end else begin
              o_next_count = i_count + L_ONE;
            end
          end else begin
            if (w_at_min) begin
              w_state_nxt  = ST_UP;
              o_next_count = L_MIN + L_ONE;
            end else begin
              o_next_count = i_count - L_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_dir   = (r_state == ST_UP);
  assign o_state = r_state;

endmodule

// File: rtl/param_updn_counter.sv
// Parameterised up/down/ping-pong counter with clamped synchronous load and a
// terminal-count flag decoded from the registered count and direction.
module param_updn_counter
  import updn_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] OUT,
  output logic             DIR,
  output logic             TC
);

  if ((WIDTH < 2) || (WIDTH > 32) || (MIN_VAL >= MAX_VAL) ||
      (longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_params
    $error("param_updn_counter: need 2<=WIDTH<=32 and MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] L_MIN = MIN_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] L_MAX = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next_count;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_lo_diff;
  logic [WIDTH-1:0] w_hi_diff;
  logic             w_below_min;
  logic             w_above_max;
  logic             w_step;
  logic             w_dir;
  dir_state_e       w_state;

  // A borrow out of the widened subtraction means the operand was out of range.
  assign {w_below_min, w_lo_diff} = {1'b0, LOAD_VAL} - {1'b0, L_MIN};
  assign {w_above_max, w_hi_diff} = {1'b0, L_MAX} - {1'b0, LOAD_VAL};

  assign w_load_clamped = w_below_min ? L_MIN :
                          w_above_max ? L_MAX : LOAD_VAL;

  assign w_step = EN & ~LOAD & (mode_e'(MODE) != MODE_HOLD);

  updn_dir_fsm #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_dir_fsm (
    .i_clk        (CLK),
    .i_rst_n      (RST),
    .i_step       (w_step),
    .i_mode       (MODE),
    .i_count      (r_count),
    .o_next_count (w_next_count),
    .o_dir        (w_dir),
    .o_state      (w_state)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        r_count <= L_MIN;
    else if (LOAD)   r_count <= w_load_clamped;
    else if (w_step) r_count <= w_next_count;
  end

  assign OUT = r_count;
  assign DIR = w_dir;
  assign TC  = (w_dir && (r_count == L_MAX)) || (!w_dir && (r_count == L_MIN));

endmodule

// File: tb/tb_param_updn_counter.sv
// Bench for param_updn_counter: three instances with different bounds share
// one stimulus stream; a reference model feeds per-instance expected queues.
module tb_param_updn_counter;

  localparam int W = 4;
  localparam int MINV [3] = '{0, 3, 4};
  localparam int MAXV [3] = '{15, 9, 5};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] out0, out1, out2;
  logic         dir0, dir1, dir2;
  logic         tc0, tc1, tc2;

  param_updn_counter #(.WIDTH(W), .MIN_VAL(0), .MAX_VAL(15)) u_dut0 (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .LOAD(load), .LOAD_VAL(load_val),
    .OUT(out0), .DIR(dir0), .TC(tc0));
  param_updn_counter #(.WIDTH(W), .MIN_VAL(3), .MAX_VAL(9)) u_dut1 (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .LOAD(load), .LOAD_VAL(load_val),
    .OUT(out1), .DIR(dir1), .TC(tc1));
  param_updn_counter #(.WIDTH(W), .MIN_VAL(4), .MAX_VAL(5)) u_dut2 (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .LOAD(load), .LOAD_VAL(load_val),
    .OUT(out2), .DIR(dir2), .TC(tc2));

  // reference model: count and direction per instance, plain integers
  int m_out [3];
  bit m_dir [3];

  int total = 0;
  int bad   = 0;

  logic [W+1:0] exp_q0[$];
  logic [W+1:0] exp_q1[$];
  logic [W+1:0] exp_q2[$];

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_out[k] = MINV[k];
      m_dir[k] = 1'b1;
    end
  endfunction

  function automatic void model_step(int k, bit ld, int lv, bit md_en, int md);
    int lo = MINV[k];
    int hi = MAXV[k];
    if (ld) begin
      m_out[k] = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
    end else if (md_en && md != 3) begin
      if (md == 0) begin
        m_dir[k] = 1'b1;
        m_out[k] = (m_out[k] == hi) ? lo : m_out[k] + 1;
      end else if (md == 1) begin
        m_dir[k] = 1'b0;
        m_out[k] = (m_out[k] == lo) ? hi : m_out[k] - 1;
      end else if (m_dir[k]) begin
        if (m_out[k] == hi) begin m_out[k] = hi - 1; m_dir[k] = 1'b0; end
        else m_out[k] = m_out[k] + 1;
      end else begin
        if (m_out[k] == lo) begin m_out[k] = lo + 1; m_dir[k] = 1'b1; end
        else m_out[k] = m_out[k] - 1;
      end
    end
  endfunction

  function automatic logic [W+1:0] model_exp(int k);
    bit tc = (m_dir[k] && m_out[k] == MAXV[k]) || (!m_dir[k] && m_out[k] == MINV[k]);
    return {W'(m_out[k]), m_dir[k], tc};
  endfunction

  function automatic void chk_entry(string name, logic [W+1:0] act, logic [W+1:0] exp);
    chk({name, ".out"}, int'(act[W+1:2]), int'(exp[W+1:2]));
    chk({name, ".dir"}, int'(act[1]), int'(exp[1]));
    chk({name, ".tc"},  int'(act[0]), int'(exp[0]));
  endfunction

  // driver: inputs applied after an edge; expected pushed when the edge captures them
  task automatic drive(bit ld, int lv, bit e, int md);
    load     = ld;
    load_val = W'(lv);
    en       = e;
    mode     = 2'(md);
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, ld, lv, e, md);
    exp_q0.push_back(model_exp(0));
    exp_q1.push_back(model_exp(1));
    exp_q2.push_back(model_exp(2));
    #1;
  endtask

  // monitor: outputs are registered, so each cycle presents one result
  always @(negedge clk) begin
    if (exp_q0.size() > 0) chk_entry("dut0", {out0, dir0, tc0}, exp_q0.pop_front());
    if (exp_q1.size() > 0) chk_entry("dut1", {out1, dir1, tc1}, exp_q1.pop_front());
    if (exp_q2.size() > 0) chk_entry("dut2", {out2, dir2, tc2}, exp_q2.pop_front());
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out0", int'(out0), 0);
    chk("rst.out1", int'(out1), 3);
    chk("rst.out2", int'(out2), 4);
    chk("rst.dir0", int'(dir0), 1);
    chk("rst.tc0",  int'(tc0), 0);
    chk("rst.tc1",  int'(tc1), 0);
    rst = 1'b1;

    // ping-pong from reset: 0,1..15,14..0,1 ; narrow instance alternates 4,5
    for (int i = 1; i <= 31; i++) begin
      drive(1'b0, 0, 1'b1, 2);
      chk("pp.out0", int'(out0), (i <= 15) ? i : ((i <= 30) ? 30 - i : i - 30));
      chk("pp.out2", int'(out2), (i % 2 == 1) ? 5 : 4);
      if (i == 15) chk("pp.tc_top", int'(tc0), 1);
      if (i == 30) chk("pp.tc_bot", int'(tc0), 1);
    end

    // wrap at the bounds
    drive(1'b1, 15, 1'b0, 0);
    drive(1'b0, 0, 1'b1, 0);
    chk("upwrap.out0", int'(out0), 0);
    chk("upwrap.dir0", int'(dir0), 1);
    drive(1'b0, 0, 1'b1, 1);
    chk("dnwrap.out0", int'(out0), 15);
    chk("dnwrap.dir0", int'(dir0), 0);

    // clamped load, load beats enable
    drive(1'b1, 12, 1'b1, 0);
    chk("clamp_hi.out1", int'(out1), 9);
    drive(1'b1, 1, 1'b1, 1);
    chk("clamp_lo.out1", int'(out1), 3);
    chk("clamp_lo.out0", int'(out0), 1);

    // hold in the middle of a descending ping-pong
    drive(1'b1, 8, 1'b0, 2);
    drive(1'b0, 0, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, 1'b1, 3);
      chk("hold.out0", int'(out0), 7);
    end
    drive(1'b0, 0, 1'b1, 2);
    chk("resume1.out0", int'(out0), 6);
    drive(1'b0, 0, 1'b1, 2);
    chk("resume2.out0", int'(out0), 5);

    // asynchronous reset between edges
    drive(1'b1, 11, 1'b0, 0);
    chk("pre_rst.out0", int'(out0), 11);
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    #1 rst = 1'b0;
    #1;
    chk("async_rst.out0", int'(out0), 0);
    chk("async_rst.dir0", int'(dir0), 1);
    chk("async_rst.tc0",  int'(tc0), 0);
    model_reset();
    #1 rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 0, 1'b1, 0);
      chk("post_rst.out0", int'(out0), i);
    end

    // randomized traffic checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)));
    end

    drive(1'b0, 0, 1'b0, 3);
    repeat (2) @(posedge clk);
    chk("drain", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_updn_counter.md
PARAM_UPDN_COUNTER -- requirements
Module: param_updn_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (2..32).
REQ-002 Parameter MIN_VAL, default 0, lower count bound.
REQ-003 Parameter MAX_VAL, default 15, upper count bound.
REQ-004 Parameters SHALL satisfy MIN_VAL < MAX_VAL <= 2**WIDTH-1; elaboration SHALL fail otherwise.
REQ-005 CLK  input  1  sole clock, rising-edge active.
REQ-006 RST  input  1  asynchronous, active-low reset.
REQ-007 EN  input  1  count enable; 0 = hold.
REQ-008 MODE  input  2  00 up-wrap, 01 down-wrap, 10 ping-pong (up/down bounce), 11 hold.
REQ-009 LOAD  input  1  synchronous load strobe.
REQ-010 LOAD_VAL  input  WIDTH  value written on LOAD.
REQ-011 OUT  output  WIDTH  registered count.
REQ-012 DIR  output  1  registered direction: 1 = up, 0 = down.
REQ-013 TC  output  1  terminal-count flag, combinational from OUT and DIR registers only.

Function
REQ-014 All state SHALL update only on rising CLK; one-cycle latency from input to OUT/DIR.
REQ-015 Priority per cycle: LOAD > (EN and MODE != 11) > hold.
REQ-016 LOAD: OUT <= LOAD_VAL clamped to [MIN_VAL, MAX_VAL]; DIR unchanged; EN ignored.
REQ-017 Up-wrap (00): OUT+1; at MAX_VAL next OUT = MIN_VAL; DIR <= 1.
REQ-018 Down-wrap (01): OUT-1; at MIN_VAL next OUT = MAX_VAL; DIR <= 0.
REQ-019 Ping-pong (10), direction FSM states UP/DOWN: in UP, OUT+1, at MAX_VAL next OUT = MAX_VAL-1 and state DOWN; in DOWN, OUT-1, at MIN_VAL next OUT = MIN_VAL+1 and state UP.
REQ-020 Ping-pong with MAX_VAL = MIN_VAL+1 SHALL alternate between the two values every enabled cycle.
REQ-021 Entering ping-pong from another mode SHALL continue in the current DIR; if OUT is already at the bound in that direction, it SHALL turn immediately (REQ-019 rules).
REQ-022 Hold (11) or EN=0: OUT and DIR unchanged.
REQ-023 TC = 1 when (DIR=1 and OUT=MAX_VAL) or (DIR=0 and OUT=MIN_VAL), else 0.
REQ-024 Arithmetic SHALL be WIDTH-bit; no intermediate overflow may escape [MIN_VAL, MAX_VAL].
REQ-025 MODE change mid-count SHALL take effect on the next enabled edge with no lost or skipped state.

Reset
REQ-026 RST=0 SHALL immediately force OUT = MIN_VAL, DIR = 1, FSM = UP, independent of CLK.
REQ-027 TC SHALL read 0 during and after reset (follows from REQ-023, MIN_VAL < MAX_VAL).
REQ-028 Deassertion mid-operation SHALL resume counting from MIN_VAL on the first rising CLK with RST=1.

Structure
REQ-029 Mode encodings (MODE_UP, MODE_DOWN, MODE_PINGPONG, MODE_HOLD) and FSM state constants SHALL live in shared package updn_pkg.
REQ-030 The direction FSM plus bound compare SHALL be sub-module updn_dir_fsm; the top holds the count register, load clamp, and TC logic.

Verification
REQ-031 Defaults, MODE=10, EN=1 from reset, 32 cycles -> OUT 0,1..15,14..0,1; TC high at OUT=15 (DIR=1) and OUT=0 (DIR=0).
REQ-032 MODE=00, EN=1, OUT=15 -> next OUT=0, DIR=1; MODE=01 at OUT=0 -> next OUT=15, DIR=0.
REQ-033 MIN_VAL=3, MAX_VAL=9: LOAD_VAL=12 -> OUT=9; LOAD_VAL=1 -> OUT=3; LOAD with EN=1 same cycle -> load wins.
REQ-034 Ping-pong at OUT=7 DIR=0, switch MODE=11 for 3 cycles then back to 10 -> OUT holds 7, resumes 6,5.
REQ-035 RST asserted between CLK edges at OUT=11 -> OUT=0, DIR=1 before next edge; release -> 1,2,3.
REQ-036 MIN_VAL=4, MAX_VAL=5, MODE=10 -> OUT 4,5,4,5 and DIR toggles every cycle.
